// File: rtl/async_arm_pkg.sv
// Shared definitions for the async ARM datapath blocks: FSM state encoding
// and default data/address widths.
// Build option: define WB_DUAL_WRITE_EN to enable the second result write
// (adds the WR2 state).
package async_arm_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 4;

`ifdef WB_DUAL_WRITE_EN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR1   = 3'd1,
      WR2   = 3'd2,
      ACK   = 3'd3,
      DRAIN = 3'd4
   } wb_state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR1   = 3'd1,
      ACK   = 3'd3,
      DRAIN = 3'd4
   } wb_state_t;
`endif

endpackage

// File: rtl/writeback_sync_ff.sv
// sync_ff: DEPTH-flop synchronizer bringing an asynchronous level into the
// clk domain. Async active-low reset clears the whole chain.
module sync_ff #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] stages;

   // Shift the incoming level through the chain; the oldest bit is the output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stages <= '0;
      end else begin
         stages <= (stages << 1) | DEPTH'(d);
      end
   end

   assign q = stages[DEPTH-1];

endmodule

// File: rtl/writeback.sv
// writeback: takes ALU results over a 2-phase toggle handshake, writes them
// into the register bank over a second 2-phase handshake, and registers the
// CPSR. Both handshake acknowledges are synchronized before use.
// Build option: WB_DUAL_WRITE_EN enables writing the second ALU result
// (dataIn2/addrIn2/w2); without it those inputs are ignored and WR2 is absent.
module writeback
   import async_arm_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] dataIn1,
   input  logic [DATA_W-1:0] dataIn2,
   input  logic [ADDR_W-1:0] addrIn1,
   input  logic [ADDR_W-1:0] addrIn2,
   input  logic              w,
   input  logic              w2,
   input  logic [DATA_W-1:0] cpsrIn,
   input  logic              readyIn,
   output logic              triggerOut,
   output logic [DATA_W-1:0] dataOutRB,
   output logic [ADDR_W-1:0] addrOutRB,
   output logic              triggerOutRB,
   input  logic              readyInRB,
   output logic [DATA_W-1:0] cpsrOut,
   output logic              busy,
   output logic [7:0]        wrCount
);

   logic      rdy_s;
   logic      ack_s;
   wb_state_t state;

`ifdef WB_DUAL_WRITE_EN
   logic [DATA_W-1:0] cap_data2;
   logic [ADDR_W-1:0] cap_addr2;
   logic              cap_w2;
`else
   logic unused_second_result;
   assign unused_second_result = ^{w2, dataIn2, addrIn2};
`endif

   sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_rdy (
      .clk   (clk),
      .reset (reset),
      .d     (readyIn),
      .q     (rdy_s)
   );

   sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_ack (
      .clk   (clk),
      .reset (reset),
      .d     (readyInRB),
      .q     (ack_s)
   );

   // Transaction FSM: capture a result, issue its regbank writes one at a time,
   // then acknowledge the ALU and wait for its ready to drop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         triggerOut   <= 1'b0;
         triggerOutRB <= 1'b0;
         dataOutRB    <= '0;
         addrOutRB    <= '0;
         cpsrOut      <= '0;
         wrCount      <= 8'd0;
`ifdef WB_DUAL_WRITE_EN
         cap_data2    <= '0;
         cap_addr2    <= '0;
         cap_w2       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (rdy_s) begin
                  cpsrOut <= cpsrIn;
`ifdef WB_DUAL_WRITE_EN
                  cap_data2 <= dataIn2;
                  cap_addr2 <= addrIn2;
                  cap_w2    <= w2;
`endif
                  if (w) begin
                     dataOutRB    <= dataIn1;
                     addrOutRB    <= addrIn1;
                     triggerOutRB <= ~triggerOutRB;
                     state        <= WR1;
`ifdef WB_DUAL_WRITE_EN
                  end else if (w2) begin
                     dataOutRB    <= dataIn2;
                     addrOutRB    <= addrIn2;
                     triggerOutRB <= ~triggerOutRB;
                     state        <= WR2;
`endif
                  end else begin
                     state <= ACK;
                  end
               end
            end
            WR1: begin
               if (ack_s == triggerOutRB) begin
                  wrCount <= wrCount + 8'd1;
`ifdef WB_DUAL_WRITE_EN
                  if (cap_w2) begin
                     dataOutRB    <= cap_data2;
                     addrOutRB    <= cap_addr2;
                     triggerOutRB <= ~triggerOutRB;
                     state        <= WR2;
                  end else begin
                     state <= ACK;
                  end
`else
                  state <= ACK;
`endif
               end
            end
`ifdef WB_DUAL_WRITE_EN
            WR2: begin
               if (ack_s == triggerOutRB) begin
                  wrCount <= wrCount + 8'd1;
                  state   <= ACK;
               end
            end
`endif
            ACK: begin
               triggerOut <= ~triggerOut;
               state      <= DRAIN;
            end
            DRAIN: begin
               if (!rdy_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_writeback.sv
// tb_writeback: scoreboard bench for writeback. A driver plays the ALU, a
// behavioural regbank answers write requests, and a monitor compares every
// regbank write and every ALU acknowledge against queued expectations.
module tb_writeback;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] dataIn1 = '0, dataIn2 = '0, cpsrIn = '0;
   logic [AW-1:0] addrIn1 = '0, addrIn2 = '0;
   logic          w = 1'b0, w2 = 1'b0, readyIn = 1'b0, readyInRB = 1'b0;
   logic          triggerOut, triggerOutRB, busy;
   logic [DW-1:0] dataOutRB, cpsrOut;
   logic [AW-1:0] addrOutRB;
   logic [7:0]    wrCount;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      logic [DW-1:0] cpsr;
      logic [7:0]    cnt;
   } done_t;

   wr_t           exp_wr_q[$];
   done_t         exp_done_q[$];
   logic [7:0]    model_count = 8'd0;
   logic [DW-1:0] rb_regs [16];
   bit            rb_stall = 1'b0;
   logic          last_t = 1'b0, last_trb = 1'b0;
   int            compared = 0;
   int            mismatched = 0;

   writeback #(.DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
      .clk          (clk),
      .reset        (reset),
      .dataIn1      (dataIn1),
      .dataIn2      (dataIn2),
      .addrIn1      (addrIn1),
      .addrIn2      (addrIn2),
      .w            (w),
      .w2           (w2),
      .cpsrIn       (cpsrIn),
      .readyIn      (readyIn),
      .triggerOut   (triggerOut),
      .dataOutRB    (dataOutRB),
      .addrOutRB    (addrOutRB),
      .triggerOutRB (triggerOutRB),
      .readyInRB    (readyInRB),
      .cpsrOut      (cpsrOut),
      .busy         (busy),
      .wrCount      (wrCount)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic reportFail(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s", name);
   endtask

   task automatic scrambleInputs();
      dataIn1 = $urandom;
      dataIn2 = $urandom;
      addrIn1 = AW'($urandom);
      addrIn2 = AW'($urandom);
      w       = 1'($urandom);
      w2      = 1'($urandom);
      cpsrIn  = $urandom;
   endtask

   // Reference model: which writes a result produces and the resulting count.
   task automatic pushExpected(input bit wi, input bit w2i, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] cp);
      int n = 0;
      if (wi) begin
         exp_wr_q.push_back('{addr: a1, data: d1});
         n++;
      end
`ifdef WB_DUAL_WRITE_EN
      if (w2i) begin
         exp_wr_q.push_back('{addr: a2, data: d2});
         n++;
      end
`else
      if (w2i && a2 === a2 && d2 === d2) n += 0;
`endif
      model_count = model_count + 8'(n);
      exp_done_q.push_back('{cpsr: cp, cnt: model_count});
   endtask

   // Play the ALU: present a result, wait for the acknowledge toggle, optionally
   // keep ready high while the inputs churn, then drop ready.
   task automatic applyStimulus(input bit wi, input bit w2i, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] cp,
                                input int hold, input bit check_lat);
      logic t0, t1;
      int   cycles = 0;
      @(negedge clk);
      dataIn1 = d1; dataIn2 = d2; addrIn1 = a1; addrIn2 = a2;
      w = wi; w2 = w2i; cpsrIn = cp;
      pushExpected(wi, w2i, a1, a2, d1, d2, cp);
      t0 = triggerOut;
      readyIn = 1'b1;
      while (triggerOut === t0 && cycles < 300) begin
         @(negedge clk);
         cycles++;
      end
      if (triggerOut === t0) begin
         reportFail("timeout_waiting_triggerOut");
      end else if (check_lat) begin
         checkOutput("ack_latency", 64'(cycles), 64'(SS + 2));
      end
      t1 = triggerOut;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         scrambleInputs();
      end
      if (hold > 0) checkOutput("held_ready_no_recapture", 64'(triggerOut), 64'(t1));
      readyIn = 1'b0;
      repeat (SS + 3) @(negedge clk);
   endtask

   // Behavioural regbank: commits each requested write after a random delay
   // and answers by matching its acknowledge to the request toggle.
   initial begin
      for (int i = 0; i < 16; i++) rb_regs[i] = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            readyInRB = 1'b0;
         end else if (!rb_stall && triggerOutRB !== readyInRB) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (reset) begin
               rb_regs[addrOutRB] = dataOutRB;
               readyInRB = triggerOutRB;
            end
         end
      end
   end

   // Monitor: every regbank request and every ALU acknowledge is checked
   // against the head of its expectation queue.
   initial begin
      wr_t   ew;
      done_t ed;
      forever begin
         @(negedge clk);
         if (!reset) begin
            last_t   = 1'b0;
            last_trb = 1'b0;
         end else begin
            if (triggerOutRB !== last_trb) begin
               last_trb = triggerOutRB;
               if (exp_wr_q.size() == 0) begin
                  reportFail("unexpected_regbank_write");
               end else begin
                  ew = exp_wr_q.pop_front();
                  checkOutput("wr_addr", 64'(addrOutRB), 64'(ew.addr));
                  checkOutput("wr_data", 64'(dataOutRB), 64'(ew.data));
               end
            end
            if (triggerOut !== last_t) begin
               last_t = triggerOut;
               if (exp_done_q.size() == 0) begin
                  reportFail("unexpected_alu_ack");
               end else begin
                  ed = exp_done_q.pop_front();
                  checkOutput("cpsrOut", 64'(cpsrOut), 64'(ed.cpsr));
                  checkOutput("wrCount", 64'(wrCount), 64'(ed.cnt));
               end
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #3_000_000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] simulation time limit reached");
   end

   // Directed scenarios, random traffic, mid-write reset and count wrap.
   initial begin
      logic tb0;
      int   cyc;

      repeat (3) @(negedge clk);
      checkOutput("reset_triggerOut", 64'(triggerOut), 64'(0));
      checkOutput("reset_triggerOutRB", 64'(triggerOutRB), 64'(0));
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_wrCount", 64'(wrCount), 64'(0));
      checkOutput("reset_cpsrOut", 64'(cpsrOut), 64'(0));
      checkOutput("reset_dataOutRB", 64'(dataOutRB), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      repeat (SS + 2) @(negedge clk);

      $display("[TB] single write");
      applyStimulus(1'b1, 1'b0, 4'd3, 4'd0, 32'h0000_00AA, 32'h0, 32'h1000_0000, 0, 1'b0);
      checkOutput("single_r3", 64'(rb_regs[3]), 64'h0000_00AA);

      $display("[TB] dual write to same register");
      applyStimulus(1'b1, 1'b1, 4'd5, 4'd5, 32'h11, 32'h22, 32'h2000_0000, 0, 1'b0);
`ifdef WB_DUAL_WRITE_EN
      checkOutput("dual_r5_final", 64'(rb_regs[5]), 64'h22);
`else
      checkOutput("dual_r5_final", 64'(rb_regs[5]), 64'h11);
`endif

      $display("[TB] no write, latency");
      applyStimulus(1'b0, 1'b0, 4'd1, 4'd2, 32'h5, 32'h6, 32'h6000_0000, 0, 1'b1);

      $display("[TB] held ready");
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h8000_0000, 20, 1'b1);
      applyStimulus(1'b1, 1'b0, 4'd9, 4'd0, 32'hDEAD_BEEF, 32'h0, 32'h4000_0000, 20, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 40; i++) begin
         logic rw, rw2;
         rw  = 1'($urandom);
         rw2 = 1'($urandom);
`ifdef WB_DUAL_WRITE_EN
         applyStimulus(rw, rw2, AW'($urandom), AW'($urandom), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 5)), !rw && !rw2);
`else
         applyStimulus(rw, rw2, AW'($urandom), AW'($urandom), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 5)), !rw);
`endif
      end

      $display("[TB] reset during pending write");
      rb_stall = 1'b1;
      @(negedge clk);
      w = 1'b1; w2 = 1'b0; addrIn1 = 4'd7; dataIn1 = 32'h7777_0000; cpsrIn = 32'hF000_0000;
      exp_wr_q.push_back('{addr: 4'd7, data: 32'h7777_0000});
      tb0 = triggerOutRB;
      readyIn = 1'b1;
      cyc = 0;
      while (triggerOutRB === tb0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (triggerOutRB === tb0) reportFail("timeout_waiting_write_request");
      repeat (3) @(negedge clk);
      readyIn = 1'b0;
      reset = 1'b0;
      #1;
      checkOutput("midreset_triggerOut", 64'(triggerOut), 64'(0));
      checkOutput("midreset_triggerOutRB", 64'(triggerOutRB), 64'(0));
      checkOutput("midreset_dataOutRB", 64'(dataOutRB), 64'(0));
      checkOutput("midreset_addrOutRB", 64'(addrOutRB), 64'(0));
      checkOutput("midreset_cpsrOut", 64'(cpsrOut), 64'(0));
      checkOutput("midreset_busy", 64'(busy), 64'(0));
      checkOutput("midreset_wrCount", 64'(wrCount), 64'(0));
      exp_wr_q.delete();
      exp_done_q.delete();
      model_count = 8'd0;
      repeat (3) @(negedge clk);
      rb_stall = 1'b0;
      reset = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("post_reset_triggerOutRB", 64'(triggerOutRB), 64'(0));
      checkOutput("post_reset_triggerOut", 64'(triggerOut), 64'(0));
      checkOutput("post_reset_busy", 64'(busy), 64'(0));

      $display("[TB] wrCount wrap over 256 writes");
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 1'b0, AW'($urandom), AW'($urandom), $urandom, $urandom, $urandom, 0, 1'b0);
         if (i == 254) checkOutput("wrCount_255", 64'(wrCount), 64'(255));
      end
      checkOutput("wrCount_wrapped", 64'(wrCount), 64'(0));

      repeat (5) @(negedge clk);
      checkOutput("scoreboard_drained", 64'(exp_wr_q.size() + exp_done_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter DATA_W, default 32, data/CPSR width.
REQ-002 Parameter ADDR_W, default 4, register-file address width (r0..r15).
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth on the readyIn and readyInRB inputs.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 dataIn1 / dataIn2  in  DATA_W  ALU results 1 and 2.
REQ-007 addrIn1 / addrIn2  in  ADDR_W  destination registers for results 1 and 2.
REQ-008 w / w2  in  1  write-enable for results 1 and 2.
REQ-009 cpsrIn  in  DATA_W  flags produced by the ALU.
REQ-010 readyIn  in  1  level from the ALU: high means the result is valid.
REQ-011 triggerOut  out  1  toggle to the ALU: each toggle accepts the current result and requests the next.
REQ-012 dataOutRB / addrOutRB  out  DATA_W / ADDR_W  regbank write data and address.
REQ-013 triggerOutRB  out  1  toggle to the regbank: each toggle is one write request.
REQ-014 readyInRB  in  1  regbank 2-phase acknowledge: a write is complete when synced readyInRB equals triggerOutRB.
REQ-015 cpsrOut  out  DATA_W  registered CPSR.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 wrCount  out  8  committed regbank writes, modulo 256.

Function
REQ-018 readyIn and readyInRB SHALL each pass through a SYNC_STAGES-flop synchronizer before use, giving rdy_s and ack_s.
REQ-019 FSM states SHALL be IDLE, WR1, WR2, ACK and DRAIN.
REQ-020 On the edge where the FSM is in IDLE and rdy_s=1, the block SHALL:
- capture dataIn1/2, addrIn1/2, w and w2;
- load cpsrOut from cpsrIn.
REQ-021 On that same edge the FSM SHALL go to:
- WR1 when w=1;
- WR2 when w=0 and w2=1;
- ACK when both are 0.
REQ-022 On entry to WR1 or WR2, the block SHALL drive dataOutRB/addrOutRB with the captured pair and toggle triggerOutRB on the same edge.
REQ-023 WR1 SHALL hold until ack_s equals triggerOutRB. It SHALL then increment wrCount and go to WR2 if the captured w2=1, else to ACK.
REQ-024 WR2 SHALL hold until ack_s equals triggerOutRB. It SHALL then increment wrCount and go to ACK.
REQ-025 ACK SHALL toggle triggerOut and go to DRAIN in one cycle.
REQ-026 DRAIN SHALL hold until rdy_s=0, then go to IDLE. This prevents one result from being accepted twice.
REQ-027 dataOutRB and addrOutRB SHALL stay stable from a write's triggerOutRB toggle until that write is acknowledged.
REQ-028 When addrIn1 equals addrIn2 and both writes are enabled, both writes SHALL be issued in order, so dataIn2 is the final value.
REQ-029 Input changes outside the IDLE capture edge SHALL be ignored.
REQ-030 Minimum latency from the ALU's readyIn rising to triggerOut toggling, with no writes: SYNC_STAGES+2 cycles.
REQ-031 wrCount SHALL wrap from 255 to 0.

Reset
REQ-032 While reset=0, the block SHALL hold:
- state IDLE;
- triggerOut=0 and triggerOutRB=0;
- dataOutRB, addrOutRB and cpsrOut all 0;
- busy=0 and wrCount=0;
- all synchronizer and capture flops at 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction immediately. The ALU and the regbank are reset by the same reset and restart at toggle parity 0.
REQ-034 After reset deasserts, the first capture SHALL occur no earlier than SYNC_STAGES+1 edges later.

Configuration
REQ-035 With macro WB_DUAL_WRITE_EN defined, the block SHALL behave as above.
REQ-036 Without WB_DUAL_WRITE_EN:
- w2, dataIn2 and addrIn2 SHALL be ignored;
- state WR2 SHALL not exist;
- WR1 SHALL always go to ACK.

Structure
REQ-037 A shared package async_arm_pkg SHALL hold the FSM state enum and the DATA_W and ADDR_W default constants.
REQ-038 The synchronizer SHALL be a sub-module sync_ff (parameterized depth), instantiated twice.

Verification
REQ-039 The bench SHALL cover these scenarios:
- Single write: w=1, addrIn1=3, dataIn1=0x0000_00AA, readyIn=1 -> one triggerOutRB toggle with addrOutRB=3 and dataOutRB=0xAA; after the ack, triggerOut toggles once and wrCount=1.
- Dual write: w=w2=1, addrIn1=addrIn2=5, dataIn1=0x11, dataIn2=0x22 -> two writes in order, regbank r5=0x22, wrCount=2.
- No write: w=w2=0, cpsrIn=0x6000_0000 -> no triggerOutRB toggle; cpsrOut=0x6000_0000; triggerOut toggles SYNC_STAGES+2 cycles after readyIn rises.
- Held ready: readyIn kept high for 20 cycles after triggerOut toggles -> no second capture; capture resumes only after readyIn goes low, then high again.
- Reset mid-WR1: reset=0 while an ack is pending -> all outputs 0, state IDLE, no further toggles.
- wrCount wrap: 256 single writes -> wrCount=0; macro undefined with w2=1 -> no second write.
